regfile_sb: RTL and testbench

Parametrised two-read, two-write register file with integrated load scoreboard, the successor to the single-write-port MIPS register bank in the core's decode stage. Port A carries ALU writeback, port B carries memory-load writeback. Per-register pending bits, set on load issue and cleared on load writeback, drive a `busy` flag per read port so the hazard unit can stall. Reads are combinational with optional same-cycle write-through bypass. Register 0 is optionally hardwired to zero.

---
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb
// Two-read, two-write register file with an integrated load scoreboard.
// Port A carries ALU writeback. Port B carries load writeback and also
// clears the destination's pending bit. A reserve request marks the
// destination of an issued load as pending. While a source register is
// pending, the matching busy flag tells the hazard unit to stall.
//
// Ports:
//   clk                 single clock; all state updates on posedge
//   rst                 synchronous active-high reset; clears data and pending
//   raddr1/2            read addresses
//   dout1/2             combinational read data
//   busy1/2             read source has an outstanding load
//   wr_a, waddr_a, din_a  ALU write port
//   wr_b, waddr_b, din_b  load write port; clears pending
//   rsv, rsv_addr       reserve request for the destination of an issued load
//   rsv_ok              reserve accepted this cycle (combinational)
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_a,
    input  logic [ADDR_W-1:0] waddr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              wr_b,
    input  logic [ADDR_W-1:0] waddr_b,
    input  logic [DATA_W-1:0] din_b,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A load writeback to the reserved register frees the slot in the same
    // cycle, so a back-to-back load to that register is accepted.
    logic clr_rsv;
    assign clr_rsv = wr_b && (waddr_b == rsv_addr);
    assign rsv_ok  = rsv && (is_zero(rsv_addr) || !pend_q[rsv_addr] || clr_rsv);

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_b && !is_zero(waddr_b)) begin
            mem_d[waddr_b]  = din_b;
            pend_d[waddr_b] = 1'b0;
        end
        // Port A applied last so it wins an address collision (younger op).
        if (wr_a && !is_zero(waddr_a)) begin
            mem_d[waddr_a] = din_a;
        end
        // Set after the clear so a same-cycle writeback + reserve leaves it set.
        if (rsv_ok && !is_zero(rsv_addr)) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        dout1 = mem_q[raddr1];
        busy1 = pend_q[raddr1];
        if (BYPASS != 0) begin
            if (wr_a && (waddr_a == raddr1)) begin
                dout1 = din_a;
            end else if (wr_b && (waddr_b == raddr1)) begin
                dout1 = din_b;
            end
            if (wr_b && (waddr_b == raddr1)) begin
                busy1 = 1'b0;
            end
        end
        if (is_zero(raddr1)) begin
            dout1 = '0;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        dout2 = mem_q[raddr2];
        busy2 = pend_q[raddr2];
        if (BYPASS != 0) begin
            if (wr_a && (waddr_a == raddr2)) begin
                dout2 = din_a;
            end else if (wr_b && (waddr_b == raddr2)) begin
                dout2 = din_b;
            end
            if (wr_b && (waddr_b == raddr2)) begin
                busy2 = 1'b0;
            end
        end
        if (is_zero(raddr2)) begin
            dout2 = '0;
            busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Drives a bypassing and a non-bypassing regfile_sb from the same stimulus.
// Directed vectors cover reset, zero register, write collision, scoreboard
// set/clear and reset during an outstanding load; a randomized phase is
// compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr1, raddr2;
    logic        wr_a, wr_b, rsv;
    logic [4:0]  waddr_a, waddr_b, rsv_addr;
    logic [31:0] din_a, din_b;

    logic [31:0] dout1, dout2, dout1_n, dout2_n;
    logic        busy1, busy2, busy1_n, busy2_n;
    logic        rsv_ok, rsv_ok_n;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .dout1(dout1), .dout2(dout2), .busy1(busy1), .busy2(busy2),
        .wr_a(wr_a), .waddr_a(waddr_a), .din_a(din_a),
        .wr_b(wr_b), .waddr_b(waddr_b), .din_b(din_b),
        .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .dout1(dout1_n), .dout2(dout2_n), .busy1(busy1_n), .busy2(busy2_n),
        .wr_a(wr_a), .waddr_a(waddr_a), .din_a(din_a),
        .wr_b(wr_b), .waddr_b(waddr_b), .din_b(din_b),
        .rsv(rsv), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_n)
    );

    // Reference model: plain arrays holding register contents and load flags.
    logic [31:0] m_mem  [32];
    bit          m_pend [32];

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && wr_a && waddr_a == a) return din_a;
        if (byp && wr_b && waddr_b == a) return din_b;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && wr_b && waddr_b == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic m_ok();
        if (!rsv) return 1'b0;
        if (rsv_addr == 5'd0) return 1'b1;
        return !m_pend[rsv_addr] || (wr_b && waddr_b == rsv_addr);
    endfunction

    task automatic model_update();
        logic ok;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            ok = m_ok();
            if (wr_b && waddr_b != 5'd0) begin
                m_mem[waddr_b]  = din_b;
                m_pend[waddr_b] = 1'b0;
            end
            if (wr_a && waddr_a != 5'd0) m_mem[waddr_a] = din_a;
            if (ok && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; wr_a = 0; waddr_a = 0; din_a = 0;
        wr_b = 0; waddr_b = 0; din_b = 0; rsv = 0; rsv_addr = 0;
    endtask

    task automatic check_model();
        chk("rnd_dout1",    dout1,    m_read(raddr1, 1));
        chk("rnd_dout2",    dout2,    m_read(raddr2, 1));
        chk("rnd_dout1_nb", dout1_n,  m_read(raddr1, 0));
        chk("rnd_dout2_nb", dout2_n,  m_read(raddr2, 0));
        chk("rnd_busy1",    32'(busy1),   32'(m_busy(raddr1, 1)));
        chk("rnd_busy2",    32'(busy2),   32'(m_busy(raddr2, 1)));
        chk("rnd_busy1_nb", 32'(busy1_n), 32'(m_busy(raddr1, 0)));
        chk("rnd_busy2_nb", 32'(busy2_n), 32'(m_busy(raddr2, 0)));
        chk("rnd_rsv_ok",   32'(rsv_ok),   32'(m_ok()));
        chk("rnd_rsv_ok_nb", 32'(rsv_ok_n), 32'(m_ok()));
    endtask

    typedef struct {
        bit          rst;
        bit          wa; logic [4:0] aa; logic [31:0] da;
        bit          wb; logic [4:0] ab; logic [31:0] db;
        bit          rv; logic [4:0] ra;
        logic [4:0]  r1, r2;
        logic [31:0] e_d1, e_d1n, e_d2, e_d2n;
        bit          e_b1, e_b1n, e_ok;
    } vec_t;

    vec_t tab [0:22];

    initial begin
        // rst wa aa da            wb ab db       rv ra  r1  r2  d1 d1n d2 d2n b1 b1n ok
        tab[0]  = '{0,1,1,32'h11,        0,0,0,         0,0,  1, 0, 32'h11,32'h0, 32'h0,32'h0, 0,0,0};
        tab[1]  = '{0,1,2,32'h22,        0,0,0,         0,0,  1, 2, 32'h11,32'h11, 32'h22,32'h0, 0,0,0};
        tab[2]  = '{0,0,0,0,             0,0,0,         1,3,  3, 2, 32'h0,32'h0, 32'h22,32'h22, 0,0,1};
        tab[3]  = '{1,0,0,0,             0,0,0,         0,0,  3, 1, 32'h0,32'h0, 32'h11,32'h11, 1,1,0};
        tab[4]  = '{0,0,0,0,             0,0,0,         0,0,  3, 1, 32'h0,32'h0, 32'h0,32'h0, 0,0,0};
        tab[5]  = '{0,0,0,0,             0,0,0,         0,0,  2, 1, 32'h0,32'h0, 32'h0,32'h0, 0,0,0};
        tab[6]  = '{0,1,5,32'hDEADBEEF,  1,0,32'h1234,  0,0,  5, 0, 32'hDEADBEEF,32'h0, 32'h0,32'h0, 0,0,0};
        tab[7]  = '{0,0,0,0,             0,0,0,         0,0,  5, 0, 32'hDEADBEEF,32'hDEADBEEF, 32'h0,32'h0, 0,0,0};
        tab[8]  = '{0,1,7,32'hAAAA,      1,7,32'hBBBB,  0,0,  7, 5, 32'hAAAA,32'h0, 32'hDEADBEEF,32'hDEADBEEF, 0,0,0};
        tab[9]  = '{0,0,0,0,             0,0,0,         0,0,  7, 7, 32'hAAAA,32'hAAAA, 32'hAAAA,32'hAAAA, 0,0,0};
        tab[10] = '{0,0,0,0,             0,0,0,         1,9,  9, 0, 32'h0,32'h0, 32'h0,32'h0, 0,0,1};
        tab[11] = '{0,0,0,0,             0,0,0,         1,9,  9, 0, 32'h0,32'h0, 32'h0,32'h0, 1,1,0};
        tab[12] = '{0,0,0,0,             1,9,32'h55,    0,0,  9, 0, 32'h55,32'h0, 32'h0,32'h0, 0,1,0};
        tab[13] = '{0,0,0,0,             0,0,0,         0,0,  9, 0, 32'h55,32'h55, 32'h0,32'h0, 0,0,0};
        tab[14] = '{0,0,0,0,             0,0,0,         1,4,  4, 0, 32'h0,32'h0, 32'h0,32'h0, 0,0,1};
        tab[15] = '{0,0,0,0,             1,4,32'h77,    1,4,  4, 0, 32'h77,32'h0, 32'h0,32'h0, 0,1,1};
        tab[16] = '{0,0,0,0,             0,0,0,         0,0,  4, 0, 32'h77,32'h77, 32'h0,32'h0, 1,1,0};
        tab[17] = '{0,0,0,0,             0,0,0,         1,12, 12,0, 32'h0,32'h0, 32'h0,32'h0, 0,0,1};
        tab[18] = '{1,1,1,32'hFF,        0,0,0,         0,0,  12,0, 32'h0,32'h0, 32'h0,32'h0, 1,1,0};
        tab[19] = '{0,0,0,0,             0,0,0,         0,0,  12,1, 32'h0,32'h0, 32'h0,32'h0, 0,0,0};
        tab[20] = '{0,0,0,0,             1,12,32'h9,    0,0,  12,5, 32'h9,32'h0, 32'h0,32'h0, 0,0,0};
        tab[21] = '{0,0,0,0,             0,0,0,         1,0,  12,4, 32'h9,32'h9, 32'h0,32'h0, 0,0,1};
        tab[22] = '{0,0,0,0,             0,0,0,         0,0,  0, 12, 32'h0,32'h0, 32'h9,32'h9, 0,0,0};

        idle();
        raddr1 = 0; raddr2 = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Every register reads zero and idle after reset.
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            @(negedge clk);
            chk("reset_dout1", dout1, 32'h0);
            chk("reset_dout2_nb", dout2_n, 32'h0);
            chk("reset_busy1", 32'(busy1), 32'h0);
            chk("reset_busy2_nb", 32'(busy2_n), 32'h0);
            tick();
        end

        for (int i = 0; i < 23; i++) begin
            rst = tab[i].rst;
            wr_a = tab[i].wa; waddr_a = tab[i].aa; din_a = tab[i].da;
            wr_b = tab[i].wb; waddr_b = tab[i].ab; din_b = tab[i].db;
            rsv = tab[i].rv;  rsv_addr = tab[i].ra;
            raddr1 = tab[i].r1; raddr2 = tab[i].r2;
            @(negedge clk);
            chk($sformatf("vec%0d_dout1", i),    dout1,   tab[i].e_d1);
            chk($sformatf("vec%0d_dout1_nb", i), dout1_n, tab[i].e_d1n);
            chk($sformatf("vec%0d_dout2", i),    dout2,   tab[i].e_d2);
            chk($sformatf("vec%0d_dout2_nb", i), dout2_n, tab[i].e_d2n);
            chk($sformatf("vec%0d_busy1", i),    32'(busy1),   32'(tab[i].e_b1));
            chk($sformatf("vec%0d_busy1_nb", i), 32'(busy1_n), 32'(tab[i].e_b1n));
            chk($sformatf("vec%0d_rsv_ok", i),   32'(rsv_ok),  32'(tab[i].e_ok));
            tick();
        end

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            wr_a     = $urandom_range(0, 1);
            waddr_a  = 5'($urandom_range(0, 7));
            din_a    = $urandom;
            wr_b     = ($urandom_range(0, 2) == 0);
            waddr_b  = 5'($urandom_range(0, 7));
            din_b    = $urandom;
            rsv      = ($urandom_range(0, 4) < 2);
            rsv_addr = 5'($urandom_range(0, 7));
            raddr1   = 5'($urandom_range(0, 7));
            raddr2   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
            @(negedge clk);
            check_model();
            tick();
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
